// File: rtl/shad_scan_reader_if.sv
// Handshake and scan-chain bundle for shad_scan_reader.
// master = the reader, slave = request source, readback consumer and shadow chain.
`timescale 1ns/1ps

interface shad_scan_reader_if #(
  parameter int width = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             shad_cap;
  logic             SE;
  logic             SI;
  logic             SO;
  logic [width-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_last;
  logic             busy;

  modport master (
    input  req_valid, SO, rd_ready,
    output req_ready, shad_cap, SE, SI, rd_data, rd_valid, rd_last, busy
  );

  modport slave (
    output req_valid, SO, rd_ready,
    input  req_ready, shad_cap, SE, SI, rd_data, rd_valid, rd_last, busy
  );
endinterface

// File: rtl/shad_scan_reader.sv
// Snapshot readback controller for a chain of DW04_shad_reg shadow registers.
// Define SHAD_SCAN_LOOPBACK_EN to feed SO back into SI so the chain survives readback.
`timescale 1ns/1ps

module shad_scan_reader #(
  parameter int width    = 8,
  parameter int num_regs = 2
) (
  input  logic               sys_clk,
  input  logic               reset,
  shad_scan_reader_if.master bus
);

  localparam int BIT_W  = $clog2(width);
  localparam int WORD_W = (num_regs > 1) ? $clog2(num_regs) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(width - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(num_regs - 1);

  if (width < 2 || width > 64) begin : g_bad_width
    $error("shad_scan_reader: width must be 2..64");
  end
  if (num_regs < 1 || num_regs > 16) begin : g_bad_num_regs
    $error("shad_scan_reader: num_regs must be 1..16");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_OUTPUT
  } state_e;

  state_e              state_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [WORD_W-1:0]   word_cnt_q;
  logic                shad_cap_q;
  logic                se_q;
  logic [width-1:0]    rd_data_q;
  logic [width-1:0]    rd_data_d;
  logic                rd_valid_q;
  logic                rd_last_q;
  logic                busy_q;

  // The chain presents bit 0 first, so each new bit enters at the MSB and
  // walks down until the first one sits in bit 0.
  assign rd_data_d = {bus.SO, rd_data_q[width-1:1]};

  // NOTE: every register below is updated with <= so all of them see the
  // pre-edge values of each other; blocking here would chain updates in one edge.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shad_cap_q <= 1'b0;
      se_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            state_q    <= S_CAPTURE;
            word_cnt_q <= '0;
            shad_cap_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        S_CAPTURE: begin
          shad_cap_q <= 1'b0;
          se_q       <= 1'b1;
          bit_cnt_q  <= '0;
          state_q    <= S_SHIFT;
        end

        S_SHIFT: begin
          rd_data_q <= rd_data_d;
          if (bit_cnt_q == BIT_LAST) begin
            se_q       <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_last_q  <= (word_cnt_q == WORD_LAST);
            state_q    <= S_OUTPUT;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end

        S_OUTPUT: begin
          // Chain stays frozen (SE low) for as long as the consumer stalls.
          if (bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            if (word_cnt_q == WORD_LAST) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              word_cnt_q <= word_cnt_q + WORD_W'(1);
              bit_cnt_q  <= '0;
              se_q       <= 1'b1;
              state_q    <= S_SHIFT;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.shad_cap  = shad_cap_q;
  assign bus.SE        = se_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.busy      = busy_q;

`ifdef SHAD_SCAN_LOOPBACK_EN
  // Recirculating the tail rotates the chain back to its captured contents.
  assign bus.SI = se_q & bus.SO;
`else
  assign bus.SI = 1'b0;
`endif

  a_no_cap_while_shifting: assert property (
    @(posedge sys_clk) disable iff (reset) !(shad_cap_q && se_q)
  );

  a_word_held_while_stalled: assert property (
    @(posedge sys_clk) disable iff (reset)
      (rd_valid_q && !bus.rd_ready) |=> (rd_valid_q && $stable(rd_data_q) && $stable(rd_last_q))
  );

endmodule

// File: tb/tb_shad_scan_reader.sv
// Bench for shad_scan_reader: an 8-bit x 2 instance and a 2-bit x 1 instance,
// each driving a behavioural shadow chain; expected words come from a word-level model.
`timescale 1ns/1ps

module tb_shad_scan_reader;

  localparam bit LOOPBACK =
`ifdef SHAD_SCAN_LOOPBACK_EN
    1'b1;
`else
    1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  shad_scan_reader_if #(.width(8)) if_a ();
  shad_scan_reader_if #(.width(2)) if_b ();

  shad_scan_reader #(.width(8), .num_regs(2)) dut_a (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (if_a)
  );

  shad_scan_reader #(.width(2), .num_regs(1)) dut_b (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (if_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Shadow chains: bit 0 is the tail bit presented on SO; shift moves toward the tail.
  // The chain holds its preload; shad_cap is observed only for timing.
  logic [15:0] chain_a, load_val_a;
  logic        load_a;
  logic [1:0]  chain_b, load_val_b;
  logic        load_b;

  always @(posedge sys_clk) begin
    if (load_a)       chain_a <= load_val_a;
    else if (if_a.SE) chain_a <= {if_a.SI, chain_a[15:1]};
  end
  always @(posedge sys_clk) begin
    if (load_b)       chain_b <= load_val_b;
    else if (if_b.SE) chain_b <= {if_b.SI, chain_b[1]};
  end
  assign if_a.SO = chain_a[0];
  assign if_b.SO = chain_b[0];

  // Word-level model of what the chains hold: word 0 is the register nearest SO.
  logic [7:0] exp_a [2];
  logic [1:0] exp_b;

  task automatic load_chain_a(input logic [7:0] tail, input logic [7:0] head);
    @(negedge sys_clk);
    load_val_a = {head, tail};
    load_a     = 1'b1;
    @(negedge sys_clk);
    load_a     = 1'b0;
    exp_a[0]   = tail;
    exp_a[1]   = head;
  endtask

  task automatic load_chain_b(input logic [1:0] v);
    @(negedge sys_clk);
    load_val_b = v;
    load_b     = 1'b1;
    @(negedge sys_clk);
    load_b     = 1'b0;
    exp_b      = v;
  endtask

  // mode 0: rd_ready high; mode 1: word 0 stalled 5 cycles; mode 2: random rd_ready.
  task automatic snapshot_a(input int mode, input bit hold_req);
    int  c, words, se_run, stall, last_hs, first_valid;
    bit  ready, in_word;
    c = 0; words = 0; se_run = 0; stall = 0; last_hs = 0; first_valid = 0; in_word = 0;
    @(negedge sys_clk);
    vectors++;
    if (if_a.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL a_req_ready_idle: got %b, expected 1", if_a.req_ready);
    end
    if_a.req_valid = 1'b1;
    if_a.rd_ready  = 1'b0;
    while (words < 2 && c < 200) begin
      @(negedge sys_clk);
      c++;
      if (!hold_req) if_a.req_valid = 1'b0;
      vectors++;
      if (if_a.shad_cap !== (c == 1)) begin
        miscompares++;
        $display("FAIL a_shad_cap cycle %0d: got %b, expected %b", c, if_a.shad_cap, (c == 1));
      end
      vectors++;
      if (if_a.busy !== 1'b1 || if_a.req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL a_busy cycle %0d: got busy=%b req_ready=%b, expected 1/0",
                 c, if_a.busy, if_a.req_ready);
      end
      if (if_a.rd_valid === 1'b1) begin
        if (!in_word) begin
          in_word = 1'b1;
          vectors++;
          if (se_run != 8) begin
            miscompares++;
            $display("FAIL a_se_length word %0d: got %0d cycles, expected 8", words, se_run);
          end
          if (words == 0) first_valid = c;
        end
        vectors++;
        if (if_a.SE !== 1'b0) begin
          miscompares++;
          $display("FAIL a_se_in_output cycle %0d: got %b, expected 0", c, if_a.SE);
        end
        vectors++;
        if (if_a.rd_data !== exp_a[words] || if_a.rd_last !== (words == 1)) begin
          miscompares++;
          $display("FAIL a_word %0d cycle %0d: got %h last=%b, expected %h last=%b",
                   words, c, if_a.rd_data, if_a.rd_last, exp_a[words], (words == 1));
        end
        case (mode)
          0:       ready = 1'b1;
          1:       ready = (words != 0) || (stall == 5);
          default: ready = 1'($urandom_range(0, 1));
        endcase
        if (!ready) stall++;
        if_a.rd_ready = ready;
        if (ready) begin
          words++;
          last_hs = c;
          in_word = 1'b0;
          se_run  = 0;
        end
      end else begin
        if_a.rd_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (if_a.SE === 1'b1) se_run++;
        else begin
          vectors++;
          if (c != 1) begin
            miscompares++;
            $display("FAIL a_gap cycle %0d: got SE=0 rd_valid=0, expected activity", c);
          end
        end
      end
    end
    vectors++;
    if (c >= 200) begin
      miscompares++;
      $display("FAIL a_timeout: got %0d words, expected 2", words);
    end
    vectors++;
    if (first_valid != 10) begin
      miscompares++;
      $display("FAIL a_first_valid: got cycle %0d, expected 10", first_valid);
    end
    if (mode == 0) begin
      vectors++;
      if (last_hs != 19) begin
        miscompares++;
        $display("FAIL a_latency: got %0d, expected 19", last_hs);
      end
    end
    @(negedge sys_clk);
    if_a.req_valid = 1'b0;
    if_a.rd_ready  = 1'b0;
    vectors++;
    if (if_a.req_ready !== 1'b1 || if_a.busy !== 1'b0 || if_a.rd_valid !== 1'b0 ||
        if_a.shad_cap !== 1'b0) begin
      miscompares++;
      $display("FAIL a_after_last: got req_ready=%b busy=%b rd_valid=%b shad_cap=%b, expected 1/0/0/0",
               if_a.req_ready, if_a.busy, if_a.rd_valid, if_a.shad_cap);
    end
    if (!LOOPBACK) begin
      exp_a[0] = 8'h00;
      exp_a[1] = 8'h00;
    end
  endtask

  task automatic snapshot_b();
    int c, first_valid;
    bit done;
    c = 0; first_valid = 0; done = 0;
    @(negedge sys_clk);
    if_b.req_valid = 1'b1;
    if_b.rd_ready  = 1'b1;
    while (!done && c < 50) begin
      @(negedge sys_clk);
      c++;
      if_b.req_valid = 1'b0;
      vectors++;
      if (if_b.shad_cap !== (c == 1) || if_b.SE !== (c == 2 || c == 3)) begin
        miscompares++;
        $display("FAIL b_timing cycle %0d: got shad_cap=%b SE=%b, expected %b/%b",
                 c, if_b.shad_cap, if_b.SE, (c == 1), (c == 2 || c == 3));
      end
      if (if_b.rd_valid === 1'b1) begin
        first_valid = c;
        done        = 1'b1;
        vectors++;
        if (if_b.rd_data !== exp_b || if_b.rd_last !== 1'b1) begin
          miscompares++;
          $display("FAIL b_word: got %b last=%b, expected %b last=1",
                   if_b.rd_data, if_b.rd_last, exp_b);
        end
      end
    end
    vectors++;
    if (first_valid != 4) begin
      miscompares++;
      $display("FAIL b_latency: got cycle %0d, expected 4", first_valid);
    end
    @(negedge sys_clk);
    if_b.rd_ready = 1'b0;
    vectors++;
    if (if_b.req_ready !== 1'b1 || if_b.rd_valid !== 1'b0 || if_b.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b_after_last: got req_ready=%b rd_valid=%b busy=%b, expected 1/0/0",
               if_b.req_ready, if_b.rd_valid, if_b.busy);
    end
    if (!LOOPBACK) exp_b = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if (if_a.shad_cap !== 1'b0 || if_a.SE !== 1'b0 || if_a.rd_valid !== 1'b0 ||
        if_a.rd_last !== 1'b0 || if_a.busy !== 1'b0 || if_a.rd_data !== 8'h00 ||
        if_a.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_a: got cap=%b se=%b v=%b l=%b busy=%b data=%h rdy=%b, expected 0/0/0/0/0/00/1",
               if_a.shad_cap, if_a.SE, if_a.rd_valid, if_a.rd_last, if_a.busy,
               if_a.rd_data, if_a.req_ready);
    end
    vectors++;
    if (if_b.busy !== 1'b0 || if_b.rd_data !== 2'b00 || if_b.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_b: got busy=%b data=%b rdy=%b, expected 0/00/1",
               if_b.busy, if_b.rd_data, if_b.req_ready);
    end
    reset = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (if_a.req_ready !== 1'b1 || if_a.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b busy=%b, expected 1/0", if_a.req_ready, if_a.busy);
    end
  endtask

  task automatic test_basic();
    load_chain_a(8'hA5, 8'h3C);
    snapshot_a(0, 1'b0);
  endtask

  task automatic test_back_pressure();
    load_chain_a(8'hA5, 8'h3C);
    snapshot_a(1, 1'b0);
  endtask

  task automatic test_busy_rejection();
    load_chain_a(8'h5A, 8'hC3);
    snapshot_a(0, 1'b1);
  endtask

  task automatic test_reset_mid_shift();
    int se_seen, n;
    se_seen = 0; n = 0;
    load_chain_a(8'hF0, 8'h0F);
    @(negedge sys_clk);
    if_a.req_valid = 1'b1;
    while (se_seen < 4 && n < 30) begin
      @(negedge sys_clk);
      n++;
      if_a.req_valid = 1'b0;
      if (if_a.SE === 1'b1) se_seen++;
    end
    vectors++;
    if (se_seen != 4) begin
      miscompares++;
      $display("FAIL mid_reset_reach: got %0d SE cycles, expected 4", se_seen);
    end
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    vectors++;
    if (if_a.SE !== 1'b0 || if_a.rd_valid !== 1'b0 || if_a.busy !== 1'b0 ||
        if_a.rd_data !== 8'h00 || if_a.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got se=%b v=%b busy=%b data=%h rdy=%b, expected 0/0/0/00/1",
               if_a.SE, if_a.rd_valid, if_a.busy, if_a.rd_data, if_a.req_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      vectors++;
      if (if_a.rd_valid !== 1'b0 || if_a.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_quiet cycle %0d: got v=%b busy=%b, expected 0/0",
                 i, if_a.rd_valid, if_a.busy);
      end
    end
  endtask

  task automatic test_loopback();
    load_chain_a(8'hA5, 8'h3C);
    snapshot_a(0, 1'b0);
    snapshot_a(0, 1'b0);
    load_chain_b(2'b10);
    snapshot_b();
    snapshot_b();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      load_chain_a(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      snapshot_a(2, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) begin
      load_chain_b(2'($urandom));
      snapshot_b();
    end
  endtask

  task automatic test_edge_params();
    load_chain_b(2'b10);
    snapshot_b();
  endtask

  initial begin
    reset          = 1'b1;
    load_a         = 1'b0;
    load_b         = 1'b0;
    load_val_a     = '0;
    load_val_b     = '0;
    if_a.req_valid = 1'b0;
    if_a.rd_ready  = 1'b0;
    if_b.req_valid = 1'b0;
    if_b.rd_ready  = 1'b0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_busy_rejection();
    test_reset_mid_shift();
    test_loopback();
    test_edge_params();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
